// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-bundle bit map and architectural register ids.
package pipe_pkg;

  localparam int unsigned CTRL_W    = 10;
  localparam int unsigned REGWRITE  = 0;
  localparam int unsigned MEMTOREG  = 1;
  localparam int unsigned MEMWRITE  = 2;
  localparam int unsigned ALUSRC    = 3;
  localparam int unsigned ALUCTL_LO = 4;
  localparam int unsigned ALUCTL_HI = 5;
  localparam int unsigned FLAGWR_LO = 6;
  localparam int unsigned FLAGWR_HI = 7;
  localparam int unsigned BRANCH    = 8;
  localparam int unsigned PCSRC     = 9;

  localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/fwd_sel.sv
// One ALU operand's forward select: Memory beats Writeback, r15 never forwarded.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  input  logic              regWriteM,
  input  logic [ADDR_W-1:0] wa3M,
  input  logic [DATA_W-1:0] aluResultM,
  input  logic              regWriteW,
  input  logic [ADDR_W-1:0] wa3W,
  input  logic [DATA_W-1:0] resultW,
  output logic [DATA_W-1:0] fwd
);

  always_comb begin
    fwd = rd;
    if (ra == ADDR_W'(PC_REG)) begin
      fwd = rd;
    end else if (regWriteM && (wa3M == ra)) begin
      fwd = aluResultM;
    end else if (regWriteW && (wa3W == ra)) begin
      fwd = resultW;
    end
  end

endmodule

// File: rtl/decode_execute_stage.sv
// D->E pipeline register with operand forwarding and load-use / branch hazard control.
module decode_execute_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [ADDR_W-1:0] ra1D,
  input  logic [ADDR_W-1:0] ra2D,
  input  logic [ADDR_W-1:0] wa3D,
  input  logic [DATA_W-1:0] extImmD,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic              regWriteM,
  input  logic [ADDR_W-1:0] wa3M,
  input  logic [DATA_W-1:0] aluResultM,
  input  logic              regWriteW,
  input  logic [ADDR_W-1:0] wa3W,
  input  logic [DATA_W-1:0] resultW,
  input  logic              branchTakenE,
  output logic [DATA_W-1:0] srcAE,
  output logic [DATA_W-1:0] writeDataE,
  output logic [DATA_W-1:0] extImmE,
  output logic [ADDR_W-1:0] wa3E,
  output logic [CTRL_W-1:0] ctrlE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD
);

  logic [DATA_W-1:0] rd1E, rd2E;
  logic [ADDR_W-1:0] ra1E, ra2E;
  logic              ldStall;
  logic              flushE;

  // A load in E whose target is read in D must wait one cycle for memory data.
  always_comb begin
    ldStall = ctrlE[MEMTOREG] & ctrlE[REGWRITE] & ((wa3E == ra1D) | (wa3E == ra2D));
    flushE  = ldStall | branchTakenE;
    stallF  = ldStall;
    stallD  = ldStall;
    flushD  = branchTakenE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1E    <= '0;
      rd2E    <= '0;
      ra1E    <= '0;
      ra2E    <= '0;
      wa3E    <= '0;
      extImmE <= '0;
      ctrlE   <= '0;
    end else if (flushE) begin
      rd1E    <= '0;
      rd2E    <= '0;
      ra1E    <= '0;
      ra2E    <= '0;
      wa3E    <= '0;
      extImmE <= '0;
      ctrlE   <= '0;
    end else begin
      rd1E    <= rd1D;
      rd2E    <= rd2D;
      ra1E    <= ra1D;
      ra2E    <= ra2D;
      wa3E    <= wa3D;
      extImmE <= extImmD;
      ctrlE   <= ctrlD;
    end
  end

  fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .ra         (ra1E),
    .rd         (rd1E),
    .regWriteM  (regWriteM),
    .wa3M       (wa3M),
    .aluResultM (aluResultM),
    .regWriteW  (regWriteW),
    .wa3W       (wa3W),
    .resultW    (resultW),
    .fwd        (srcAE)
  );

  fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .ra         (ra2E),
    .rd         (rd2E),
    .regWriteM  (regWriteM),
    .wa3M       (wa3M),
    .aluResultM (aluResultM),
    .regWriteW  (regWriteW),
    .wa3W       (wa3W),
    .resultW    (resultW),
    .fwd        (writeDataE)
  );

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: forwarding table plus reset, load-use and branch sequences.
module tb_decode_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd1D, rd2D, extImmD, aluResultM, resultW;
  logic [3:0]  ra1D, ra2D, wa3D, wa3M, wa3W;
  logic [9:0]  ctrlD;
  logic        regWriteM, regWriteW, branchTakenE;
  logic [31:0] srcAE, writeDataE, extImmE;
  logic [3:0]  wa3E;
  logic [9:0]  ctrlE;
  logic        stallF, stallD, flushD;

  int errors = 0;
  int checks = 0;

  decode_execute_stage dut (
    .clk(clk), .reset(reset),
    .rd1D(rd1D), .rd2D(rd2D), .ra1D(ra1D), .ra2D(ra2D), .wa3D(wa3D),
    .extImmD(extImmD), .ctrlD(ctrlD),
    .regWriteM(regWriteM), .wa3M(wa3M), .aluResultM(aluResultM),
    .regWriteW(regWriteW), .wa3W(wa3W), .resultW(resultW),
    .branchTakenE(branchTakenE),
    .srcAE(srcAE), .writeDataE(writeDataE), .extImmE(extImmE),
    .wa3E(wa3E), .ctrlE(ctrlE),
    .stallF(stallF), .stallD(stallD), .flushD(flushD)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  ra1, ra2, wa3;
    logic [31:0] rd1, rd2, imm;
    logic [9:0]  ctrl;
    logic        rwm;
    logic [3:0]  wam;
    logic [31:0] alum;
    logic        rww;
    logic [3:0]  waw;
    logic [31:0] resw;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // ra1 ra2 wa3  rd1   rd2   imm  ctrl  rwm wam alum  rww waw resw  exp_a exp_b
    vecs[0] = '{4'd3, 4'd4, 4'd7, 32'h11, 32'h22, 32'h100, 10'h001,
                1'b1, 4'd3, 32'hAAAA0001, 1'b1, 4'd3, 32'hBBBB, 32'hAAAA0001, 32'h22};
    vecs[1] = '{4'd6, 4'd5, 4'd1, 32'h66, 32'h55, 32'hFF, 10'h0F9,
                1'b1, 4'd9, 32'hDEAD, 1'b1, 4'd5, 32'h1234, 32'h66, 32'h1234};
    vecs[2] = '{4'd15, 4'd15, 4'd2, 32'h108, 32'h108, 32'h0, 10'h200,
                1'b1, 4'd15, 32'hBAD, 1'b1, 4'd15, 32'hBAD2, 32'h108, 32'h108};
    vecs[3] = '{4'd8, 4'd9, 4'd4, 32'h88, 32'h99, 32'h7, 10'h3FD,
                1'b0, 4'd8, 32'hBAD3, 1'b1, 4'd8, 32'h8888, 32'h8888, 32'h99};
    vecs[4] = '{4'd0, 4'd0, 4'd3, 32'h1, 32'h2, 32'h8, 10'h00C,
                1'b1, 4'd0, 32'hA0, 1'b0, 4'd0, 32'hB0, 32'hA0, 32'hA0};
    vecs[5] = '{4'd10, 4'd11, 4'd12, 32'hAA, 32'hBB, 32'hCC, 10'h000,
                1'b0, 4'd10, 32'h1, 1'b0, 4'd11, 32'h2, 32'hAA, 32'hBB};

    reset = 1'b1;
    rd1D = '0; rd2D = '0; ra1D = '0; ra2D = '0; wa3D = '0; extImmD = '0; ctrlD = '0;
    regWriteM = 1'b0; wa3M = '0; aluResultM = '0;
    regWriteW = 1'b0; wa3W = '0; resultW = '0; branchTakenE = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("reset_ctrlE", 32'(ctrlE), 32'h0);
    chk("reset_srcAE", srcAE, 32'h0);
    chk("reset_stallF", 32'(stallF), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Forwarding table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ra1D = vecs[i].ra1; ra2D = vecs[i].ra2; wa3D = vecs[i].wa3;
      rd1D = vecs[i].rd1; rd2D = vecs[i].rd2; extImmD = vecs[i].imm; ctrlD = vecs[i].ctrl;
      regWriteM = vecs[i].rwm; wa3M = vecs[i].wam; aluResultM = vecs[i].alum;
      regWriteW = vecs[i].rww; wa3W = vecs[i].waw; resultW = vecs[i].resw;
      @(posedge clk); #1;
      chk($sformatf("v%0d_srcAE", i), srcAE, vecs[i].exp_a);
      chk($sformatf("v%0d_writeDataE", i), writeDataE, vecs[i].exp_b);
      chk($sformatf("v%0d_extImmE", i), extImmE, vecs[i].imm);
      chk($sformatf("v%0d_wa3E", i), 32'(wa3E), 32'(vecs[i].wa3));
      chk($sformatf("v%0d_ctrlE", i), 32'(ctrlE), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_stallF", i), 32'(stallF), 32'h0);
    end
    regWriteM = 1'b0; regWriteW = 1'b0;

    // Reset asserted between edges clears E immediately
    @(negedge clk);
    ctrlD = 10'h3FF; wa3D = 4'd7; extImmD = 32'h77; ra1D = 4'd1; ra2D = 4'd2;
    @(posedge clk); #1;
    chk("pre_reset_ctrlE", 32'(ctrlE), 32'h3FF);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_ctrlE", 32'(ctrlE), 32'h0);
    chk("midreset_wa3E", 32'(wa3E), 32'h0);
    chk("midreset_extImmE", extImmE, 32'h0);
    chk("midreset_stallF", 32'(stallF), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ctrlE", 32'(ctrlE), 32'h3FF);
    chk("post_reset_wa3E", 32'(wa3E), 32'h7);

    // Load-use: load to r2, then consumer of r2
    @(negedge clk);
    ctrlD = 10'h003; wa3D = 4'd2; ra1D = 4'd1; ra2D = 4'd3; extImmD = 32'h40;
    @(posedge clk); #1;
    chk("ld_ctrlE", 32'(ctrlE), 32'h003);
    @(negedge clk);
    ctrlD = 10'h001; wa3D = 4'd6; ra1D = 4'd4; ra2D = 4'd2; extImmD = 32'h55;
    #1;
    chk("lu_stallF", 32'(stallF), 32'h1);
    chk("lu_stallD", 32'(stallD), 32'h1);
    chk("lu_flushD", 32'(flushD), 32'h0);
    @(posedge clk); #1;
    chk("lu_bubble_ctrlE", 32'(ctrlE), 32'h0);
    chk("lu_bubble_wa3E", 32'(wa3E), 32'h0);
    chk("lu_release_stallF", 32'(stallF), 32'h0);
    @(posedge clk); #1;
    chk("lu_adv_ctrlE", 32'(ctrlE), 32'h001);
    chk("lu_adv_wa3E", 32'(wa3E), 32'h6);
    chk("lu_adv_extImmE", extImmE, 32'h55);

    // Branch taken flushes E and D
    @(negedge clk);
    ctrlD = 10'h001; wa3D = 4'd5; ra1D = 4'd7; ra2D = 4'd8; extImmD = 32'h99;
    branchTakenE = 1'b1;
    #1;
    chk("br_flushD", 32'(flushD), 32'h1);
    chk("br_stallF", 32'(stallF), 32'h0);
    @(posedge clk); #1;
    chk("br_ctrlE", 32'(ctrlE), 32'h0);
    chk("br_wa3E", 32'(wa3E), 32'h0);

    // Branch coinciding with load-use
    @(negedge clk);
    branchTakenE = 1'b0;
    ctrlD = 10'h003; wa3D = 4'd9; ra1D = 4'd0; ra2D = 4'd1;
    @(posedge clk); #1;
    chk("brld_ctrlE", 32'(ctrlE), 32'h003);
    @(negedge clk);
    ctrlD = 10'h001; wa3D = 4'd3; ra1D = 4'd9; ra2D = 4'd4;
    branchTakenE = 1'b1;
    #1;
    chk("both_stallF", 32'(stallF), 32'h1);
    chk("both_stallD", 32'(stallD), 32'h1);
    chk("both_flushD", 32'(flushD), 32'h1);
    @(posedge clk); #1;
    chk("both_ctrlE", 32'(ctrlE), 32'h0);
    @(negedge clk);
    branchTakenE = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
